// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state type, default widths and packed-port slicing helpers
package regfile_pkg;
   typedef enum logic {CLEAR, RUN} state_t;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
   function automatic int lo(input int p, input int w);
      return p * w;
   endfunction
endpackage

// File: rtl/regfile_sb.sv
// regfile_sb: pending-write scoreboard with per-port busy lookup
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NRD = 2,
   parameter int NWR = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [NWR-1:0]        we,
   input  logic [NWR*ADDR_W-1:0] waddr,
   input  logic                  rsv_valid,
   input  logic [ADDR_W-1:0]     rsv_addr,
   input  logic [NRD*ADDR_W-1:0] raddr,
   output logic [NRD-1:0]        rbusy
);
   localparam int NREG = 2**ADDR_W;
   logic [NREG-1:0] busy, busy_n;
   always_comb begin
      busy_n = busy;
      for (int q = 0; q < NWR; q++)
         if (we[q]) busy_n[waddr[lo(q, ADDR_W) +: ADDR_W]] = 1'b0;
      // reservation applied last so it wins over a same-cycle write
      if (rsv_valid && rsv_addr != '0) busy_n[rsv_addr] = 1'b1;
      busy_n[0] = 1'b0;
   end
   always_ff @(posedge clk)
      if (rst) busy <= '0;
      else if (en) busy <= busy_n;
   always_comb begin
      rbusy = '0;
      for (int p = 0; p < NRD; p++) begin
         logic hit;
         hit = 1'b0;
         for (int q = 0; q < NWR; q++)
            if (we[q] && waddr[lo(q, ADDR_W) +: ADDR_W] == raddr[lo(p, ADDR_W) +: ADDR_W]) hit = 1'b1;
         rbusy[p] = en && raddr[lo(p, ADDR_W) +: ADDR_W] != '0 && !hit && busy[raddr[lo(p, ADDR_W) +: ADDR_W]];
      end
   end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with bypass, RAW scoreboard and post-reset clear engine
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NRD = 2,
   parameter int NWR = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  ready,
   input  logic [NWR-1:0]        we,
   input  logic [NWR*ADDR_W-1:0] waddr,
   input  logic [NWR*DATA_W-1:0] wdata,
   input  logic [NRD-1:0]        re,
   input  logic [NRD*ADDR_W-1:0] raddr,
   output logic [NRD*DATA_W-1:0] rdata,
   output logic [NRD-1:0]        rbusy,
   input  logic                  rsv_valid,
   input  logic [ADDR_W-1:0]     rsv_addr
);
   localparam int NREG = 2**ADDR_W;
   logic [DATA_W-1:0] regs [NREG];
   state_t state, state_n;
   logic [ADDR_W-1:0] cnt;
   logic run;
   assign run = state == RUN;
   assign ready = run;
   always_comb begin
      state_n = state;
      if (state == CLEAR && cnt == ADDR_W'(NREG - 1)) state_n = RUN;
   end
   always_ff @(posedge clk)
      if (rst) begin
         state <= CLEAR;
         cnt <= '0;
      end else begin
         state <= state_n;
         if (state == CLEAR) cnt <= cnt + 1'b1;
      end
   // no reset on the array: it is zeroed by the clear sweep instead
   always_ff @(posedge clk)
      if (!rst && state == CLEAR) regs[cnt] <= '0;
      else if (!rst && run)
         for (int q = 0; q < NWR; q++)
            if (we[q] && waddr[lo(q, ADDR_W) +: ADDR_W] != '0)
               regs[waddr[lo(q, ADDR_W) +: ADDR_W]] <= wdata[lo(q, DATA_W) +: DATA_W];
   always_comb begin
      rdata = '0;
      for (int p = 0; p < NRD; p++)
         if (run && re[p] && raddr[lo(p, ADDR_W) +: ADDR_W] != '0) begin
            rdata[lo(p, DATA_W) +: DATA_W] = regs[raddr[lo(p, ADDR_W) +: ADDR_W]];
            for (int q = 0; q < NWR; q++)
               if (we[q] && waddr[lo(q, ADDR_W) +: ADDR_W] == raddr[lo(p, ADDR_W) +: ADDR_W])
                  rdata[lo(p, DATA_W) +: DATA_W] = wdata[lo(q, DATA_W) +: DATA_W];
         end
   end
   regfile_sb #(.ADDR_W(ADDR_W), .NRD(NRD), .NWR(NWR)) u_sb (
      .clk(clk),
      .rst(rst),
      .en(run),
      .we(we),
      .waddr(waddr),
      .rsv_valid(rsv_valid),
      .rsv_addr(rsv_addr),
      .raddr(raddr),
      .rbusy(rbusy)
   );
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp
module tb_regfile_mp;
   logic        clk = 1'b0;
   logic        rst;
   logic        ready;
   logic [1:0]  we;
   logic [9:0]  waddr;
   logic [63:0] wdata;
   logic [1:0]  re;
   logic [9:0]  raddr;
   logic [63:0] rdata;
   logic [1:0]  rbusy;
   logic        rsv_valid;
   logic [4:0]  rsv_addr;
   int tests = 0;
   int fails = 0;
   regfile_mp dut (
      .clk(clk), .rst(rst), .ready(ready), .we(we), .waddr(waddr), .wdata(wdata),
      .re(re), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
      .rsv_valid(rsv_valid), .rsv_addr(rsv_addr)
   );
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      we = '0; waddr = '0; wdata = '0; re = '0; raddr = '0; rsv_valid = 1'b0; rsv_addr = '0;
   endtask
   task automatic wait_ready(output int n);
      n = 0;
      while (!ready && n < 40) begin
         tick();
         n++;
      end
   endtask
   task automatic test_reset();
      int n;
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      we = 2'b01; waddr = 10'd5; wdata = 64'hDEAD;
      re = 2'b01; raddr = 10'd5;
      #1;
      tests++;
      if (ready !== 1'b0 || rdata !== 64'h0 || rbusy !== 2'b00) begin
         fails++;
         $display("FAIL reset_state: ready=%b rdata=%h rbusy=%b, need 0/0/0", ready, rdata, rbusy);
      end
      wait_ready(n);
      tests++;
      if (n !== 32) begin
         fails++;
         $display("FAIL clear_latency: %0d edges, need 32", n);
      end
      idle();
      re = 2'b01;
      for (int r = 0; r < 32; r++) begin
         raddr = 10'(r);
         #1;
         tests++;
         if (rdata[31:0] !== 32'h0) begin
            fails++;
            $display("FAIL cleared_reg%0d: got %h need 0", r, rdata[31:0]);
         end
      end
   endtask
   task automatic test_conflict();
      idle();
      we = 2'b11; waddr = {5'd7, 5'd7}; wdata = {32'h2222, 32'h1111};
      re = 2'b01; raddr = {5'd0, 5'd7};
      #1;
      tests++;
      if (rdata[31:0] !== 32'h2222) begin
         fails++;
         $display("FAIL conflict_bypass: got %h need 2222", rdata[31:0]);
      end
      tick();
      we = '0;
      #1;
      tests++;
      if (rdata[31:0] !== 32'h2222) begin
         fails++;
         $display("FAIL conflict_stored: got %h need 2222", rdata[31:0]);
      end
   endtask
   task automatic test_bypass();
      idle();
      we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'h0, 32'hCAFEBABE};
      re = 2'b11; raddr = {5'd3, 5'd3};
      #1;
      tests++;
      if (rdata !== {32'hCAFEBABE, 32'hCAFEBABE}) begin
         fails++;
         $display("FAIL bypass_both: got %h need cafebabecafebabe", rdata);
      end
      tick();
      we = 2'b10; waddr = {5'd0, 5'd0}; wdata = {32'hFFFFFFFF, 32'h0};
      re = 2'b01; raddr = {5'd3, 5'd0};
      #1;
      tests++;
      if (rdata[31:0] !== 32'h0) begin
         fails++;
         $display("FAIL reg0_bypass: got %h need 0", rdata[31:0]);
      end
      tick();
      we = '0;
      re = 2'b10; raddr = {5'd3, 5'd3};
      #1;
      tests++;
      if (rdata !== {32'hCAFEBABE, 32'h0}) begin
         fails++;
         $display("FAIL re_gate: got %h need cafebabe00000000", rdata);
      end
      re = 2'b01; raddr = {5'd3, 5'd0};
      #1;
      tests++;
      if (rdata[31:0] !== 32'h0) begin
         fails++;
         $display("FAIL reg0_stored: got %h need 0", rdata[31:0]);
      end
   endtask
   task automatic test_scoreboard();
      idle();
      raddr = {5'd0, 5'd9};
      rsv_valid = 1'b1; rsv_addr = 5'd9;
      #1;
      tests++;
      if (rbusy !== 2'b00) begin
         fails++;
         $display("FAIL rsv_same_cycle: rbusy=%b need 00", rbusy);
      end
      tick();
      rsv_valid = 1'b0;
      #1;
      tests++;
      if (rbusy !== 2'b01) begin
         fails++;
         $display("FAIL rsv_set: rbusy=%b need 01", rbusy);
      end
      we = 2'b10; waddr = {5'd9, 5'd0}; wdata = {32'h99, 32'h0};
      #1;
      tests++;
      if (rbusy !== 2'b00) begin
         fails++;
         $display("FAIL write_cycle: rbusy=%b need 00", rbusy);
      end
      tick();
      we = '0;
      #1;
      tests++;
      if (rbusy !== 2'b00) begin
         fails++;
         $display("FAIL write_cleared: rbusy=%b need 00", rbusy);
      end
      we = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'h0, 32'h77};
      rsv_valid = 1'b1; rsv_addr = 5'd9;
      tick();
      idle();
      raddr = {5'd0, 5'd9};
      #1;
      tests++;
      if (rbusy !== 2'b01) begin
         fails++;
         $display("FAIL rsv_wins: rbusy=%b need 01", rbusy);
      end
      rsv_valid = 1'b1; rsv_addr = 5'd0;
      tick();
      rsv_valid = 1'b0;
      raddr = {5'd0, 5'd0};
      #1;
      tests++;
      if (rbusy !== 2'b00) begin
         fails++;
         $display("FAIL rsv_reg0: rbusy=%b need 00", rbusy);
      end
      we = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'h0, 32'h77};
      tick();
      idle();
   endtask
   task automatic test_reset_mid();
      int n;
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      tests++;
      if (ready !== 1'b0) begin
         fails++;
         $display("FAIL mid_reset_ready: got %b need 0", ready);
      end
      wait_ready(n);
      tests++;
      if (n !== 32) begin
         fails++;
         $display("FAIL mid_reset_latency: %0d edges, need 32", n);
      end
   endtask
   task automatic test_reset_run();
      int n;
      idle();
      we = 2'b01; waddr = {5'd0, 5'd4}; wdata = {32'h0, 32'h55};
      rsv_valid = 1'b1; rsv_addr = 5'd4;
      tick();
      idle();
      re = 2'b01; raddr = {5'd0, 5'd4};
      #1;
      tests++;
      if (rbusy !== 2'b01 || rdata[31:0] !== 32'h55) begin
         fails++;
         $display("FAIL run_setup: rbusy=%b rdata=%h need 01/55", rbusy, rdata[31:0]);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wait_ready(n);
      tests++;
      if (n !== 32) begin
         fails++;
         $display("FAIL run_reset_latency: %0d edges, need 32", n);
      end
      tests++;
      if (rbusy !== 2'b00 || rdata[31:0] !== 32'h0) begin
         fails++;
         $display("FAIL run_reset_state: rbusy=%b rdata=%h need 00/0", rbusy, rdata[31:0]);
      end
   endtask
   initial begin
      idle();
      rst = 1'b1;
      test_reset();
      test_conflict();
      test_bypass();
      test_scoreboard();
      test_reset_mid();
      test_reset_run();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
